// File: rtl/img_pkg.sv
// Shared definitions for the image_write receive path: FSM encodings,
// pixel-pair width, BMP byte-lane offsets and small packing helpers.
package img_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } img_state_t;

  localparam int PAIR_W = 48;

  // BMP stores each pixel as B,G,R at ascending byte addresses.
  localparam int OFF_B0 = 0;
  localparam int OFF_G0 = 8;
  localparam int OFF_R0 = 16;
  localparam int OFF_B1 = 24;
  localparam int OFF_G1 = 32;
  localparam int OFF_R1 = 40;

  function automatic logic [PAIR_W-1:0] pack_pair(
    input logic [7:0] r0, input logic [7:0] g0, input logic [7:0] b0,
    input logic [7:0] r1, input logic [7:0] g1, input logic [7:0] b1
  );
    logic [PAIR_W-1:0] w;
    w = '0;
    w[OFF_B0 +: 8] = b0;
    w[OFF_G0 +: 8] = g0;
    w[OFF_R0 +: 8] = r0;
    w[OFF_B1 +: 8] = b1;
    w[OFF_G1 +: 8] = g1;
    w[OFF_R1 +: 8] = r1;
    return w;
  endfunction

  function automatic logic [31:0] byte_sum(input logic [PAIR_W-1:0] w);
    return 32'(w[7:0]) + 32'(w[15:8]) + 32'(w[23:16])
         + 32'(w[31:24]) + 32'(w[39:32]) + 32'(w[47:40]);
  endfunction

endpackage

// File: rtl/img_wr_fifo.sv
// Synchronous FIFO buffering {address, pixel pair} words between the
// pixel receiver and the frame-memory write port. Head entry is read
// combinationally; a push into a full FIFO is legal when a pop happens
// in the same cycle (the freed slot is the one being written).
module img_wr_fifo #(
  parameter int W     = 66,
  parameter int DEPTH = 8
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] store [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = store[rptr[AW-1:0]];

  // Pointer update; extra MSB distinguishes full from empty.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty gates the head.
  always_ff @(posedge HCLK) begin
    if (do_push) store[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/image_write.sv
// image_write: receives two RGB888 pixels per HCLK while HSYNC is high,
// tracks row/col, packs each pair into a BMP-ordered 48-bit word with a
// bottom-up address, buffers it and drains it through a valid/ready port.
// Optional build macro IMG_WRITE_CHECKSUM_EN adds frame_checksum.
//
// Write handshake: mem_valid is high whenever the FIFO holds a word;
// mem_addr/mem_wdata are the head entry and stay stable until the cycle
// in which mem_valid && mem_ready, which is when the word is consumed.
module image_write
  import img_pkg::*;
#(
  parameter int WIDTH      = 768,
  parameter int HEIGHT     = 512,
  parameter int ADDR_W     = 18,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              VSYNC,
  input  logic              HSYNC,
  input  logic [7:0]        DATA_R0,
  input  logic [7:0]        DATA_G0,
  input  logic [7:0]        DATA_B0,
  input  logic [7:0]        DATA_R1,
  input  logic [7:0]        DATA_G1,
  input  logic [7:0]        DATA_B1,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [47:0]       mem_wdata,
  output logic              write_done,
  output logic              overflow,
  output logic              line_err,
  output logic [1:0]        dbg_state
`ifdef IMG_WRITE_CHECKSUM_EN
  ,
  output logic [31:0]       frame_checksum
`endif
);

  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT + 1);
  localparam int ENT_W = ADDR_W + PAIR_W;

  img_state_t         state, state_nxt;
  logic [ROW_W-1:0]   row, cur_row;
  logic [COL_W-1:0]   col, cur_col;
  logic               hsync_q;
  logic               fresh, vsync_hit, beat, last_col, last_beat;
  logic               line_fall, push, pop, drop, full, empty;
  logic [ADDR_W-1:0]  beat_addr;
  logic [PAIR_W-1:0]  pair;
  logic [ENT_W-1:0]   fifo_dout;

  // A beat in IDLE/DONE starts a new frame at row 0, col 0.
  assign fresh     = (state == ST_IDLE) || (state == ST_DONE);
  assign vsync_hit = VSYNC && (state != ST_DRAIN);
  assign beat      = HSYNC && !vsync_hit && (state != ST_DRAIN);
  assign cur_row   = fresh ? '0 : row;
  assign cur_col   = fresh ? '0 : col;
  assign last_col  = (cur_col == COL_W'(WIDTH - 2));
  assign last_beat = last_col && (cur_row == ROW_W'(HEIGHT - 1));
  assign line_fall = (state == ST_RECV) && hsync_q && !HSYNC && (col != '0) && !vsync_hit;

  assign pop  = mem_valid && mem_ready;
  assign push = beat && (!full || pop);
  assign drop = beat && !push;

  assign pair      = pack_pair(DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1);
  assign beat_addr = (ADDR_W'(HEIGHT - 1) - ADDR_W'(cur_row)) * ADDR_W'(WIDTH / 2)
                   + ADDR_W'(cur_col >> 1);

  img_wr_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .push    (push),
    .pop     (pop),
    .din     ({beat_addr, pair}),
    .dout    (fifo_dout),
    .full    (full),
    .empty   (empty)
  );

  assign mem_valid  = !empty;
  assign mem_addr   = empty ? '0 : fifo_dout[ENT_W-1:PAIR_W];
  assign mem_wdata  = empty ? '0 : fifo_dout[PAIR_W-1:0];
  assign write_done = (state == ST_DONE);
  assign dbg_state  = state;

  // State register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state: frame start, last beat, drain completion; VSYNC overrides.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (beat) state_nxt = last_beat ? ST_DRAIN : ST_RECV;
      ST_RECV:          if (beat && last_beat) state_nxt = ST_DRAIN;
      ST_DRAIN:         if (empty) state_nxt = ST_DONE;
      default:          state_nxt = ST_IDLE;
    endcase
    if (vsync_hit) state_nxt = ST_IDLE;
  end

  // Geometry counters: advance on every beat, dropped or not.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      row     <= '0;
      col     <= '0;
      hsync_q <= 1'b0;
    end else begin
      hsync_q <= HSYNC;
      if (vsync_hit || (beat && last_beat)) begin
        row <= '0;
        col <= '0;
      end else if (beat) begin
        if (last_col) begin
          row <= cur_row + ROW_W'(1);
          col <= '0;
        end else begin
          row <= cur_row;
          col <= cur_col + COL_W'(2);
        end
      end else if (line_fall) begin
        row <= row + ROW_W'(1);
        col <= '0;
      end
    end
  end

  // Sticky error flags, cleared when a new frame starts.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      overflow <= 1'b0;
      line_err <= 1'b0;
    end else if (beat && fresh) begin
      overflow <= drop;
      line_err <= 1'b0;
    end else begin
      if (drop)      overflow <= 1'b1;
      if (line_fall) line_err <= 1'b1;
    end
  end

`ifdef IMG_WRITE_CHECKSUM_EN
  // Byte sum of accepted beats; restarts with each frame, frozen after it.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      frame_checksum <= '0;
    end else if (beat && fresh) begin
      frame_checksum <= push ? byte_sum(pair) : 32'd0;
    end else if ((state == ST_RECV) && push) begin
      frame_checksum <= frame_checksum + byte_sum(pair);
    end
  end
`endif

endmodule

// File: tb/tb_image_write.sv
// Directed testbench for image_write on an 8x4 frame.
module tb_image_write;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int AW = 18;
  localparam int DW = AW + 48;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          vsync, hsync, mem_ready;
  logic [7:0]    r0, g0, b0, r1, g1, b1;
  logic          mem_valid, write_done, overflow, line_err;
  logic [AW-1:0] mem_addr;
  logic [47:0]   mem_wdata;
  logic [1:0]    dbg_state;
`ifdef IMG_WRITE_CHECKSUM_EN
  logic [31:0]   frame_checksum;
`endif

  image_write #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .FIFO_DEPTH(8)) dut (
    .HCLK       (clk),
    .HRESETn    (rst_n),
    .VSYNC      (vsync),
    .HSYNC      (hsync),
    .DATA_R0    (r0),
    .DATA_G0    (g0),
    .DATA_B0    (b0),
    .DATA_R1    (r1),
    .DATA_G1    (g1),
    .DATA_B1    (b1),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .write_done (write_done),
    .overflow   (overflow),
    .line_err   (line_err),
    .dbg_state  (dbg_state)
`ifdef IMG_WRITE_CHECKSUM_EN
    ,
    .frame_checksum (frame_checksum)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] obs_addr[$];
  logic [47:0]   obs_data[$];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] pack(input logic [7:0] pr0, input logic [7:0] pg0,
                                       input logic [7:0] pb0, input logic [7:0] pr1,
                                       input logic [7:0] pg1, input logic [7:0] pb1);
    return {pr1, pg1, pb1, pr0, pg0, pb0};
  endfunction

  // Bottom-up word address for pixel pair at (row, col).
  function automatic logic [AW-1:0] addr_of(input int row, input int col);
    return AW'((H - 1 - row) * (W / 2) + col / 2);
  endfunction

  // Scoreboard: every accepted write must match the next expected word.
  always @(negedge clk) begin
    if (rst_n && mem_valid && mem_ready) begin
      obs_addr.push_back(mem_addr);
      obs_data.push_back(mem_wdata);
      if (exp_q.size() == 0) check("wr_extra", 1, 0);
      else check("wr", {mem_addr, mem_wdata}, exp_q.pop_front());
    end
  end

  // Driver: one beat at frame position idx; caller is just past a posedge.
  task automatic send_raw(input int idx, input logic [7:0] vr0, input logic [7:0] vg0,
                          input logic [7:0] vb0, input logic [7:0] vr1,
                          input logic [7:0] vg1, input logic [7:0] vb1, input bit keep);
    hsync = 1'b1;
    r0 = vr0; g0 = vg0; b0 = vb0; r1 = vr1; g1 = vg1; b1 = vb1;
    if (keep) exp_q.push_back({addr_of(idx / (W / 2), (idx % (W / 2)) * 2),
                               pack(vr0, vg0, vb0, vr1, vg1, vb1)});
    @(posedge clk); #1;
  endtask

  task automatic send_px(input int k, input int idx, input bit keep);
    send_raw(idx, 8'(k), 8'(k + 16), 8'(k + 32), 8'(k + 64), 8'(k + 80), 8'(k + 96), keep);
  endtask

  task automatic pulse_vsync(input logic hs);
    vsync = 1'b1; hsync = hs;
    @(posedge clk); #1;
    vsync = 1'b0; hsync = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check(tag, DW'(exp_q.size()), 0);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!write_done && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check(tag, DW'(write_done), 1);
  endtask

  initial begin
    int n;
    vsync = 0; hsync = 0; mem_ready = 1;
    r0 = 0; g0 = 0; b0 = 0; r1 = 0; g1 = 0; b1 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", DW'(mem_valid), 0);
    check("rst_done", DW'(write_done), 0);
    check("rst_ovf", DW'(overflow), 0);
    check("rst_lerr", DW'(line_err), 0);
    check("rst_addr", DW'(mem_addr), 0);
    check("rst_data", DW'(mem_wdata), 0);
    check("rst_state", DW'(dbg_state), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full frame, pair k: R0=k, G0=k+16, B0=k+32.
    obs_addr.delete(); obs_data.delete();
    for (int i = 0; i < 16; i++) send_px(i, i, 1'b1);
    hsync = 1'b0;
    n = 0;
    while (!write_done && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check("done_latency_1_2", DW'(n >= 1 && n <= 2), 1);
    wait_drain("full_drain");
    check("full_count", DW'(obs_addr.size()), 16);
    check("first_addr", DW'(obs_addr[0]), 12);
    // k=0: B0=0x20 in [7:0], G0=0x10 in [15:8], R0=0x00 in [23:16].
    check("first_lo24", DW'(obs_data[0][23:0]), 24'h001020);
    check("last_addr", DW'(obs_addr[15]), 3);
    check("full_ovf", DW'(overflow), 0);
    check("full_lerr", DW'(line_err), 0);
    check("full_done", DW'(write_done), 1);

    // Backpressure: 10 beats with ready low; 8 buffered, beats 8 and 9 dropped.
    obs_addr.delete(); obs_data.delete();
    mem_ready = 1'b0;
    for (int i = 0; i < 10; i++) send_px(i + 40, i, i < 8);
    check("bp_ovf_mid", DW'(overflow), 1);
    mem_ready = 1'b1;
    for (int i = 10; i < 16; i++) send_px(i + 40, i, 1'b1);
    hsync = 1'b0;
    wait_done("bp_done");
    wait_drain("bp_drain");
    check("bp_count", DW'(obs_addr.size()), 14);
    check("bp_ovf", DW'(overflow), 1);

    // Simultaneous push/pop on a full FIFO keeps the beat.
    mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_px(i + 100, i, 1'b1);
    mem_ready = 1'b1;
    send_px(108, 8, 1'b1);
    check("simul_ovf_now", DW'(overflow), 0);
    for (int i = 9; i < 16; i++) send_px(i + 100, i, 1'b1);
    hsync = 1'b0;
    wait_done("simul_done");
    wait_drain("simul_drain");
    check("simul_ovf", DW'(overflow), 0);

    // Short line: two beats then HSYNC low; next beat lands at row 1, col 0.
    obs_addr.delete(); obs_data.delete();
    send_px(150, 0, 1'b1);
    send_px(151, 1, 1'b1);
    hsync = 1'b0;
    @(posedge clk); #1;
    check("short_lerr", DW'(line_err), 1);
    send_px(152, 4, 1'b1);
    hsync = 1'b0;
    wait_drain("short_drain");
    check("short_next_addr", DW'(obs_addr[obs_addr.size() - 1]), 8);

    // VSYNC after 6 beats: next beat restarts at row 0.
    pulse_vsync(1'b0);
    check("vs_state_idle", DW'(dbg_state), 0);
    obs_addr.delete(); obs_data.delete();
    for (int i = 0; i < 6; i++) send_px(i + 200, i, 1'b1);
    check("vs_lerr_cleared", DW'(line_err), 0);
    pulse_vsync(1'b1);
    send_px(230, 0, 1'b1);
    hsync = 1'b0;
    wait_drain("vs_drain");
    check("vs_count", DW'(obs_addr.size()), 7);
    check("vs_restart_addr", DW'(obs_addr[6]), 12);

    // All-ones frame; checksum is 16 beats * 6 bytes.
    pulse_vsync(1'b0);
    for (int i = 0; i < 16; i++) send_raw(i, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 1'b1);
    hsync = 1'b0;
    wait_done("ones_done");
    wait_drain("ones_drain");
`ifdef IMG_WRITE_CHECKSUM_EN
    check("checksum", DW'(frame_checksum), 96);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
